smpl_sweep_ctrl: RTL and testbench
==================================

Name: smpl_sweep_ctrl

Overview:
Self-checking sweep controller for the 3-input/2-output smpl_circuit datapath (inputs A,B,C; outputs x,y).
- On `start`, drives all 8 input combinations onto the circuit, lets each settle, captures x/y into a result table and compares against an expected table.
- Reports completion, mismatch count and pass/fail.
- Sits beside smpl_circuit on-chip as a built-in exhaustive checker, replacing hand-sequenced stimulus.

Parameters:
- SETTLE_CYC, 2, clock cycles held per vector before sampling; legal range 1..15.
- N_VEC, 8, number of input vectors (2^3); fixed, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only when idle.
- abort  input  1  cancels a sweep in progress; ignored when idle.
- exp_table  input  16  expected outputs; bits [2i+1:2i] = {x,y} for vector i, where i = {A,B,C} and A is the MSB.
- dut_x  input  1  x output of smpl_circuit.
- dut_y  input  1  y output of smpl_circuit.
- drv_a  output  1  A input to smpl_circuit.
- drv_b  output  1  B input to smpl_circuit.
- drv_c  output  1  C input to smpl_circuit.
- busy  output  1  high from the edge that accepts `start` until DONE exits.
- done  output  1  one-cycle pulse at normal completion.
- vec_idx  output  3  current vector index.
- result  output  16  captured {x,y} table, same bit mapping as exp_table.
- err_cnt  output  4  number of mismatching vectors, 0..8.
- pass  output  1  high after a completed sweep with err_cnt==0; held until next start or reset.

Behaviour:
- Reset (async, rst=1): state IDLE; drv_a/b/c=0, busy=0, done=0, vec_idx=0, result=16'h0000, err_cnt=0, pass=0, settle counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 (edge E0):
  - vec_idx<=0, {drv_a,drv_b,drv_c}<=3'b000.
  - result<=0, err_cnt<=0, pass<=0, busy<=1.
  - go to DRIVE.
- DRIVE: one cycle; load settle counter with SETTLE_CYC; go to SETTLE.
- SETTLE: decrement the counter each cycle; after exactly SETTLE_CYC cycles go to SAMPLE.
- SAMPLE, at its edge:
  - result[2*vec_idx+1 : 2*vec_idx] <= {dut_x,dut_y}.
  - If the captured pair != the exp_table slot, err_cnt<=err_cnt+1.
  - If vec_idx==7, go to DONE.
  - Else vec_idx<=vec_idx+1, drv<=vec_idx+1, go to DRIVE.
- Per-vector period is SETTLE_CYC+2 cycles. Drive values change only on the edge that enters DRIVE (or E0).
- Completion timing:
  - Last sample edge = E0 + 8*(SETTLE_CYC+2). That edge enters DONE and sets done=1, pass=(final err_cnt==0).
  - The next edge: done<=0, busy<=0, state IDLE.
  - The final comparison is included in pass.
  - With SETTLE_CYC=2: done is high for the single cycle after edge E0+32.
- After completion: drv_a/b/c hold 3'b111 and vec_idx holds 7 until the next start.
- start while busy (including DONE): ignored; no restart.
- abort while busy (any non-IDLE state):
  - Next edge goes to IDLE; busy=0, done stays 0, pass=0.
  - result, err_cnt, vec_idx and drv keep their partial values.
- abort and start together: in IDLE, start is taken; when busy, abort is taken.
- err_cnt saturates naturally at 8; the 4-bit width makes overflow impossible.
- rst asserted mid-sweep: immediate return to reset values. There is no done pulse and no partial results are preserved.

Decomposition:
- Shared package smpl_pkg:
  - state encoding (3-bit localparams S_IDLE..S_DONE).
  - N_VEC=8, VEC_W=3, OUT_W=2, TBL_W=16.
- One natural sub-module: smpl_settle_timer. It is a loadable down-counter with a `load`/`expired` interface, parameterised by SETTLE_CYC.
- The FSM, vector counter, capture and compare logic stay in smpl_sweep_ctrl.

Test Plan:
- Reset check: assert rst mid-sweep at vector 3. Required: all outputs return to reset values asynchronously, with no done pulse.
- Full pass: smpl_circuit stub with x=A^B^C, y=A&B, exp_table=16'hD228, start at E0, SETTLE_CYC=2. Required: drive sequence 000..111, each held 4 cycles; done high one cycle after E0+32; result=16'hD228, err_cnt=0, pass=1.
- Single mismatch: same stub, exp_table=16'hD229. Required: result=16'hD228, err_cnt=1, pass=0, done pulses.
- All mismatch: stub driving x=y=0, exp_table=16'hFFFF. Required: result=16'h0000, err_cnt=8, pass=0.
- Abort: abort asserted during SETTLE of vector 5. Required: busy falls next edge; done never pulses; pass=0; result slots 0-4 hold captured data and slots 5-7 are 0; vec_idx=5.
- Start-while-busy and timing: pulse start again at E0+10, and run with SETTLE_CYC=1. Required: the second start is ignored; with SETTLE_CYC=1, done is high one cycle after E0+24.

Source files
------------

// File: rtl/smpl_pkg.sv
// Shared constants and state encoding for the smpl_circuit sweep checker.
package smpl_pkg;

   localparam int N_VEC = 8;
   localparam int VEC_W = 3;
   localparam int OUT_W = 2;
   localparam int TBL_W = 16;
   localparam int ERR_W = 4;
   localparam int CNT_W = 4;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_DRIVE  = 3'd1;
   localparam state_t S_SETTLE = 3'd2;
   localparam state_t S_SAMPLE = 3'd3;
   localparam state_t S_DONE   = 3'd4;

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

endpackage

// File: rtl/smpl_sweep_ctrl_if.sv
// Control, stimulus and result bundle between the sweep controller and its user.
interface smpl_sweep_ctrl_if;

   logic                        start;
   logic                        abort;
   logic [smpl_pkg::TBL_W-1:0]  exp_table;
   logic                        dut_x;
   logic                        dut_y;
   logic                        drv_a;
   logic                        drv_b;
   logic                        drv_c;
   logic                        busy;
   logic                        done;
   logic [smpl_pkg::VEC_W-1:0]  vec_idx;
   logic [smpl_pkg::TBL_W-1:0]  result;
   logic [smpl_pkg::ERR_W-1:0]  err_cnt;
   logic                        pass;

   modport master (
      output start, abort, exp_table, dut_x, dut_y,
      input  drv_a, drv_b, drv_c, busy, done, vec_idx, result, err_cnt, pass
   );

   modport slave (
      input  start, abort, exp_table, dut_x, dut_y,
      output drv_a, drv_b, drv_c, busy, done, vec_idx, result, err_cnt, pass
   );

endinterface

// File: rtl/smpl_settle_timer.sv
// Loadable down-counter; expired marks the last cycle of the settle window.
module smpl_settle_timer
   import smpl_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(SETTLE_CYC);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Terminal count of 1: the edge that drains the counter is the one leaving SETTLE.
   assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/smpl_sweep_ctrl.sv
// Exhaustive built-in checker for smpl_circuit: walks all 8 {A,B,C} vectors,
// captures {x,y} per vector and counts mismatches against exp_table.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold last sweep
//   DRIVE  | new vector on drv_a/b/c, settle timer loaded
//   SETTLE | waiting SETTLE_CYC cycles for the circuit to settle
//   SAMPLE | capture {x,y}, compare, advance or finish
//   DONE   | one-cycle done pulse, then back to IDLE
module smpl_sweep_ctrl
   import smpl_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic           clk,
   input  logic           rst,
   smpl_sweep_ctrl_if.slave bus
);

   state_t state;
   state_t state_nxt;

   logic             tmr_load;
   logic             tmr_expired;

   logic [VEC_W-1:0] vec_q, vec_d;
   logic [VEC_W-1:0] drv_q, drv_d;
   logic [TBL_W-1:0] res_q, res_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [3:0]       slot_lsb;
   logic [OUT_W-1:0] cap;
   logic [OUT_W-1:0] exp_slot;

   assign tmr_load = (state == S_DRIVE);

   smpl_settle_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .expired (tmr_expired)
   );

   assign slot_lsb = {vec_q, 1'b0};
   assign cap      = {bus.dut_x, bus.dut_y};
   assign exp_slot = bus.exp_table[slot_lsb +: OUT_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (bus.start) state_nxt = S_DRIVE;
         S_DRIVE:  state_nxt = bus.abort ? S_IDLE : S_SETTLE;
         S_SETTLE: begin
            if (bus.abort)        state_nxt = S_IDLE;
            else if (tmr_expired) state_nxt = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (bus.abort)             state_nxt = S_IDLE;
            else if (vec_q == LAST_VEC) state_nxt = S_DONE;
            else                       state_nxt = S_DRIVE;
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      vec_d  = vec_q;
      drv_d  = drv_q;
      res_d  = res_q;
      err_d  = err_q;
      pass_d = pass_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (state == S_IDLE) begin
         if (bus.start) begin
            vec_d  = '0;
            drv_d  = '0;
            res_d  = '0;
            err_d  = '0;
            pass_d = 1'b0;
            busy_d = 1'b1;
         end
      end else if (bus.abort) begin
         // Partial captures stay visible for debug; only the status is cleared.
         busy_d = 1'b0;
         pass_d = 1'b0;
      end else begin
         unique case (state)
            S_SAMPLE: begin
               res_d[slot_lsb +: OUT_W] = cap;
               if (cap != exp_slot) err_d = err_q + 1'b1;
               if (vec_q == LAST_VEC) begin
                  done_d = 1'b1;
                  pass_d = (err_d == '0);
               end else begin
                  vec_d = vec_q + 1'b1;
                  drv_d = vec_q + 1'b1;
               end
            end
            S_DONE:  busy_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q  <= '0;
         drv_q  <= '0;
         res_q  <= '0;
         err_q  <= '0;
         pass_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         vec_q  <= vec_d;
         drv_q  <= drv_d;
         res_q  <= res_d;
         err_q  <= err_d;
         pass_q <= pass_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bus.drv_a   = drv_q[2];
   assign bus.drv_b   = drv_q[1];
   assign bus.drv_c   = drv_q[0];
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.vec_idx = vec_q;
   assign bus.result  = res_q;
   assign bus.err_cnt = err_q;
   assign bus.pass    = pass_q;

endmodule

// File: tb/tb_smpl_sweep_ctrl.sv
// Bench for smpl_sweep_ctrl: two instances (SETTLE_CYC 2 and 1) sharing one
// configurable smpl_circuit stub, checked against a truth-table level model.
module tb_smpl_sweep_ctrl;

   logic clk = 1'b0;
   logic rst;

   logic [1:0]       start_v;
   logic [1:0]       abort_v;
   logic [1:0][15:0] exp_v;
   bit               use_logic;
   logic [15:0]      stub_tbl;

   int n_checks = 0;
   int n_pass   = 0;

   smpl_sweep_ctrl_if bus0 ();
   smpl_sweep_ctrl_if bus1 ();

   smpl_sweep_ctrl #(.SETTLE_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   smpl_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   assign bus0.start     = start_v[0];
   assign bus0.abort     = abort_v[0];
   assign bus0.exp_table = exp_v[0];
   assign bus1.start     = start_v[1];
   assign bus1.abort     = abort_v[1];
   assign bus1.exp_table = exp_v[1];

   // smpl_circuit: real logic (x=A^B^C, y=A&B) or an arbitrary truth table
   assign bus0.dut_x = use_logic ? (bus0.drv_a ^ bus0.drv_b ^ bus0.drv_c)
                                 : stub_tbl[{bus0.drv_a, bus0.drv_b, bus0.drv_c, 1'b1}];
   assign bus0.dut_y = use_logic ? (bus0.drv_a & bus0.drv_b)
                                 : stub_tbl[{bus0.drv_a, bus0.drv_b, bus0.drv_c, 1'b0}];
   assign bus1.dut_x = use_logic ? (bus1.drv_a ^ bus1.drv_b ^ bus1.drv_c)
                                 : stub_tbl[{bus1.drv_a, bus1.drv_b, bus1.drv_c, 1'b1}];
   assign bus1.dut_y = use_logic ? (bus1.drv_a & bus1.drv_b)
                                 : stub_tbl[{bus1.drv_a, bus1.drv_b, bus1.drv_c, 1'b0}];

   logic [1:0][2:0]  o_drv;
   logic [1:0]       o_busy, o_done, o_pass;
   logic [1:0][2:0]  o_vec;
   logic [1:0][15:0] o_res;
   logic [1:0][3:0]  o_err;

   assign o_drv[0]  = {bus0.drv_a, bus0.drv_b, bus0.drv_c};
   assign o_drv[1]  = {bus1.drv_a, bus1.drv_b, bus1.drv_c};
   assign o_busy    = {bus1.busy, bus0.busy};
   assign o_done    = {bus1.done, bus0.done};
   assign o_pass    = {bus1.pass, bus0.pass};
   assign o_vec[0]  = bus0.vec_idx;
   assign o_vec[1]  = bus1.vec_idx;
   assign o_res[0]  = bus0.result;
   assign o_res[1]  = bus1.result;
   assign o_err[0]  = bus0.err_cnt;
   assign o_err[1]  = bus1.err_cnt;

   function automatic int ref_errs(input logic [15:0] got, input logic [15:0] want);
      int n = 0;
      for (int i = 0; i < 8; i++)
         if (got[2*i +: 2] != want[2*i +: 2]) n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_v = '0; abort_v = '0; exp_v = '0;
      use_logic = 1'b1; stub_tbl = '0;
      repeat (2) tick();
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if ({o_drv[s], o_busy[s], o_done[s], o_vec[s], o_res[s], o_err[s], o_pass[s]} !== 29'd0)
            $display("FAIL reset_vals[%0d]: got %h want 0", s,
                     {o_drv[s], o_busy[s], o_done[s], o_vec[s], o_res[s], o_err[s], o_pass[s]});
         else n_pass++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_sweep();
      bit saw_done = 0;
      use_logic = 1'b1; exp_v[0] = 16'hD228;
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      for (int i = 0; i < 40 && o_vec[0] != 3'd3; i++) tick();
      n_checks++;
      if (o_vec[0] !== 3'd3) $display("FAIL reach_vec3: got %0d want 3", o_vec[0]);
      else n_pass++;
      tick();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({o_drv[0], o_busy[0], o_done[0], o_vec[0], o_res[0], o_err[0], o_pass[0]} !== 29'd0)
         $display("FAIL rst_async: got %h want 0",
                  {o_drv[0], o_busy[0], o_done[0], o_vec[0], o_res[0], o_err[0], o_pass[0]});
      else n_pass++;
      repeat (3) begin tick(); if (o_done[0]) saw_done = 1; end
      rst = 1'b0;
      repeat (12) begin tick(); if (o_done[0] || o_busy[0]) saw_done = 1; end
      n_checks++;
      if (saw_done) $display("FAIL rst_no_done: got activity after reset want none");
      else n_pass++;
   endtask

   task automatic run_sweep(input int sel, input string name, input logic [15:0] exp_tbl,
                            input logic [15:0] want_res, input int want_err, input bit dbl);
      int per = (sel == 0) ? 4 : 3;
      int last = 8 * per;
      int done_at = -1;
      int done_n = 0;
      bit drv_bad = 0;
      bit busy_bad = 0;
      logic [2:0] exp_drv;
      exp_v[sel] = exp_tbl;
      start_v[sel] = 1'b1;
      tick();
      start_v[sel] = 1'b0;
      for (int k = 0; k <= last + 4; k++) begin
         if (k > 0) tick();
         exp_drv = (k < last) ? 3'(k / per) : 3'd7;
         if (o_drv[sel] !== exp_drv || o_vec[sel] !== exp_drv) drv_bad = 1;
         if (o_busy[sel] !== (k <= last)) busy_bad = 1;
         if (o_done[sel] === 1'b1) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         start_v[sel] = (dbl && (k == 9 || k == last)) ? 1'b1 : 1'b0;
      end
      start_v[sel] = 1'b0;
      n_checks++;
      if (drv_bad) $display("FAIL %s_drv_seq: drive/vec_idx deviated from 0..7 at %0d cycles each", name, per);
      else n_pass++;
      n_checks++;
      if (busy_bad) $display("FAIL %s_busy: busy window wrong, want high through cycle %0d", name, last);
      else n_pass++;
      n_checks++;
      if (done_at != last || done_n != 1)
         $display("FAIL %s_done: got first at %0d count %0d want at %0d count 1", name, done_at, done_n, last);
      else n_pass++;
      n_checks++;
      if (o_res[sel] !== want_res) $display("FAIL %s_result: got %h want %h", name, o_res[sel], want_res);
      else n_pass++;
      n_checks++;
      if (o_err[sel] !== 4'(want_err)) $display("FAIL %s_err_cnt: got %0d want %0d", name, o_err[sel], want_err);
      else n_pass++;
      n_checks++;
      if (o_pass[sel] !== (want_err == 0)) $display("FAIL %s_pass: got %b want %b", name, o_pass[sel], want_err == 0);
      else n_pass++;
   endtask

   task automatic test_full_pass();
      use_logic = 1'b1;
      run_sweep(0, "full_pass", 16'hD228, 16'hD228, 0, 0);
   endtask

   task automatic test_single_mismatch();
      use_logic = 1'b1;
      run_sweep(0, "one_mis", 16'hD229, 16'hD228, 1, 0);
   endtask

   task automatic test_all_mismatch();
      use_logic = 1'b0; stub_tbl = 16'h0000;
      run_sweep(0, "all_mis", 16'hFFFF, 16'h0000, 8, 0);
   endtask

   task automatic test_abort();
      bit bad = 0;
      use_logic = 1'b1; exp_v[0] = 16'hD229;
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      for (int k = 1; k <= 21; k++) begin tick(); if (o_done[0]) bad = 1; end
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      n_checks++;
      if (o_busy[0] !== 1'b0) $display("FAIL abort_busy: got %b want 0", o_busy[0]);
      else n_pass++;
      repeat (6) begin tick(); if (o_done[0] || o_busy[0]) bad = 1; end
      n_checks++;
      if (bad) $display("FAIL abort_quiet: got done/busy activity want none");
      else n_pass++;
      n_checks++;
      if ({o_pass[0], o_vec[0], o_drv[0]} !== {1'b0, 3'd5, 3'd5})
         $display("FAIL abort_state: got pass %b vec %0d drv %0d want 0 5 5", o_pass[0], o_vec[0], o_drv[0]);
      else n_pass++;
      n_checks++;
      if (o_res[0] !== 16'h0228) $display("FAIL abort_result: got %h want 0228", o_res[0]);
      else n_pass++;
      n_checks++;
      if (o_err[0] !== 4'd1) $display("FAIL abort_err_cnt: got %0d want 1", o_err[0]);
      else n_pass++;
   endtask

   task automatic test_start_while_busy();
      use_logic = 1'b1;
      run_sweep(0, "restart_s2", 16'hD228, 16'hD228, 0, 1);
      run_sweep(1, "restart_s1", 16'hD228, 16'hD228, 0, 1);
   endtask

   task automatic test_random();
      logic [15:0] stub, expt;
      for (int it = 0; it < 8; it++) begin
         use_logic = 1'b0;
         stub = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       expt = stub;
            1:       expt = stub ^ (16'h1 << $urandom_range(0, 15));
            default: expt = 16'($urandom);
         endcase
         stub_tbl = stub;
         run_sweep(int'($urandom_range(0, 1)), $sformatf("rand%0d", it), expt, stub,
                   ref_errs(stub, expt), bit'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reset_mid_sweep();
      test_full_pass();
      test_single_mismatch();
      test_all_mismatch();
      test_abort();
      test_start_while_busy();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
